// File: rtl/centroid_pkt_pkg.sv
// Shared types and wire-format helpers for the 8-byte centroid telemetry packet.
// Wire format: A5, {7'b0,x1[8]}, x1[7:0], y1, {7'b0,x2[8]}, x2[7:0], y2, XOR(payload).
package centroid_pkt_pkg;

  localparam logic [7:0] SYNC_BYTE         = 8'hA5;
  localparam int         PKT_PAYLOAD_BYTES = 6;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK
  } rx_state_t;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
  } centroid_t;

  // Transmit-side view: three payload bytes for one centroid.
  function automatic logic [23:0] pack_centroid(input centroid_t c);
    return {7'b0, c.x[8], c.x[7:0], c.y};
  endfunction

  // Receive-side view: reserved high bits are checked separately, so only 17 bits come in.
  function automatic centroid_t unpack_centroid(input logic [16:0] raw);
    centroid_t c;
    c.x = raw[16:8];
    c.y = raw[7:0];
    return c;
  endfunction

endpackage

// File: rtl/centroid_packet_rx_byte_gap_timer.sv
// Counts idle clocks between bytes; expire is combinational in the cycle count hits TIMEOUT_CYCLES-1.
// A clear in the expiry cycle suppresses expire; no backpressure.
module byte_gap_timer #(
  parameter int TIMEOUT_CYCLES = 70000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expire = enable && !clear && (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clear || !enable) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + 1'b1;
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/centroid_packet_rx.sv
// Reassembles and validates centroid packets from a UART byte stream.
// Results appear one cycle after the CHK byte (or timeout); no backpressure, bytes are never stalled.
module centroid_packet_rx
  import centroid_pkt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 70000,
  parameter int MAX_X          = 320,
  parameter int MAX_Y          = 180
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        byte_valid_in,
  input  logic [7:0]  byte_in,
  output logic [8:0]  c1_x_out,
  output logic [7:0]  c1_y_out,
  output logic [8:0]  c2_x_out,
  output logic [7:0]  c2_y_out,
  output logic        centroids_valid_out,
  output logic        error_out,
  output logic [15:0] frame_count_out,
  output logic [7:0]  error_count_out,
  output logic        busy_out
);

  localparam logic [2:0] LAST_IDX = 3'(PKT_PAYLOAD_BYTES - 1);
  localparam logic [9:0] X_LIM    = 10'(MAX_X);
  localparam logic [8:0] Y_LIM    = 9'(MAX_Y);

  rx_state_t   state;
  rx_state_t   state_nxt;
  logic [2:0]  idx;
  logic [7:0]  xor_acc;
  logic        fmt_err;
  logic [16:0] c1_raw;
  logic [16:0] c2_raw;
  centroid_t   rx_c1;
  centroid_t   rx_c2;
  logic        pkt_in_range;
  logic        pkt_accept;
  logic        pkt_reject;
  logic        timer_expire;

  byte_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk   (clk_in),
    .rst_n (rst_in),
    .clear (byte_valid_in),
    .enable(state != HUNT),
    .expire(timer_expire)
  );

  assign rx_c1 = unpack_centroid(c1_raw);
  assign rx_c2 = unpack_centroid(c2_raw);
  assign pkt_in_range = ({1'b0, rx_c1.x} < X_LIM) && ({1'b0, rx_c2.x} < X_LIM) &&
                        ({1'b0, rx_c1.y} < Y_LIM) && ({1'b0, rx_c2.y} < Y_LIM);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // A byte in the expiry cycle wins, so bytes are tested before the timer.
  always_comb begin
    state_nxt = state;
    case (state)
      HUNT: begin
        if (byte_valid_in && (byte_in == SYNC_BYTE)) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        if (byte_valid_in) begin
          if (idx == LAST_IDX) state_nxt = CHECK;
        end else if (timer_expire) begin
          state_nxt = HUNT;
        end
      end
      CHECK: begin
        if (byte_valid_in || timer_expire) state_nxt = HUNT;
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_comb begin
    busy_out   = (state != HUNT);
    pkt_accept = 1'b0;
    pkt_reject = 1'b0;
    if ((state == CHECK) && byte_valid_in) begin
      if ((byte_in == xor_acc) && !fmt_err && pkt_in_range) begin
        pkt_accept = 1'b1;
      end else begin
        pkt_reject = 1'b1;
      end
    end else if ((state != HUNT) && timer_expire) begin
      pkt_reject = 1'b1;
    end
  end

  // Only the meaningful bits of each payload byte are kept; reserved bits feed fmt_err.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      idx     <= '0;
      xor_acc <= '0;
      fmt_err <= 1'b0;
      c1_raw  <= '0;
      c2_raw  <= '0;
    end else if (byte_valid_in) begin
      if (state == HUNT) begin
        idx     <= '0;
        xor_acc <= '0;
        fmt_err <= 1'b0;
      end else if (state == PAYLOAD) begin
        idx     <= idx + 3'd1;
        xor_acc <= xor_acc ^ byte_in;
        case (idx)
          3'd0: begin
            c1_raw[16] <= byte_in[0];
            if (|byte_in[7:1]) fmt_err <= 1'b1;
          end
          3'd1: c1_raw[15:8] <= byte_in;
          3'd2: c1_raw[7:0]  <= byte_in;
          3'd3: begin
            c2_raw[16] <= byte_in[0];
            if (|byte_in[7:1]) fmt_err <= 1'b1;
          end
          3'd4: c2_raw[15:8] <= byte_in;
          3'd5: c2_raw[7:0]  <= byte_in;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      c1_x_out            <= '0;
      c1_y_out            <= '0;
      c2_x_out            <= '0;
      c2_y_out            <= '0;
      centroids_valid_out <= 1'b0;
      error_out           <= 1'b0;
      frame_count_out     <= '0;
      error_count_out     <= '0;
    end else begin
      centroids_valid_out <= pkt_accept;
      error_out           <= pkt_reject;
      if (pkt_accept) begin
        c1_x_out        <= rx_c1.x;
        c1_y_out        <= rx_c1.y;
        c2_x_out        <= rx_c2.x;
        c2_y_out        <= rx_c2.y;
        frame_count_out <= frame_count_out + 16'd1;
      end
      if (pkt_reject && (error_count_out != 8'hFF)) begin
        error_count_out <= error_count_out + 8'd1;
      end
    end
  end

endmodule

// File: doc/centroid_packet_rx.md
Name: centroid_packet_rx

Overview:
Receive-side parser for the centroid telemetry link. It consumes bytes from a uart_receive instance (new_data_out / data_byte_out) and reassembles the 8-byte centroid packet emitted by the k-means FPGA's UART transmitter. It validates the sync byte, checksum, field format and coordinate range, then presents the two centroids (x 9b, y 8b) with a one-cycle valid strobe. It sits on the second FPGA (fpga_rx path) or any consumer board, feeding tracking/display logic.

Parameters:
TIMEOUT_CYCLES, 70000, idle clocks allowed between bytes inside a packet before abort (about 4 byte times at 200 MHz / 115200 baud)
MAX_X, 320, exclusive upper bound on x coordinates
MAX_Y, 180, exclusive upper bound on y coordinates

Ports:
clk_in  input  1  system clock (clk_camera domain, 200 MHz)
rst_in  input  1  synchronous, active-low reset
byte_valid_in  input  1  one-cycle strobe, new byte from uart_receive
byte_in  input  8  received byte
c1_x_out  output  9  centroid 1 x, last accepted packet
c1_y_out  output  8  centroid 1 y
c2_x_out  output  9  centroid 2 x
c2_y_out  output  8  centroid 2 y
centroids_valid_out  output  1  one-cycle pulse when outputs update
error_out  output  1  one-cycle pulse on any rejected or aborted packet
frame_count_out  output  16  accepted packets, wraps
error_count_out  output  8  rejected plus timed-out packets, saturates at 255
busy_out  output  1  high while not in HUNT

Behaviour:
- Packet format, 8 bytes: 0xA5 sync; C1 = {7'b0,x[8]}, x[7:0], y; C2 = same three bytes; CHK = XOR of the 6 payload bytes. The sync byte is not part of the XOR.
- Reset (rst_in==0 at posedge): state HUNT, all outputs 0, counters 0, timer 0. Reset mid-packet discards the partial packet and raises no error pulse.
- States:
  - HUNT: ignore bytes other than 0xA5; on 0xA5 go to PAYLOAD with idx=0, running XOR=0, fmt_err=0.
  - PAYLOAD: on each byte, store it at idx, XOR it in, idx++. Byte at idx 0 or 3 with bits[7:1]!=0 sets fmt_err. After idx 5, go to CHECK. 0xA5 inside the payload is data and never resyncs.
  - CHECK: on the byte, accept if byte==XOR, fmt_err==0, both x<MAX_X and both y<MAX_Y. Otherwise reject. Either way return to HUNT.
- Accept: on the cycle after the CHK byte strobe, all four coordinate outputs load together, centroids_valid_out=1 for exactly that cycle, and frame_count_out increments.
- Reject: outputs hold previous values, error_out pulses 1 cycle (same timing as valid), error_count_out increments (saturating).
- Timeout: in PAYLOAD/CHECK, timer counts clocks without byte_valid_in and resets on every byte. When timer==TIMEOUT_CYCLES-1 with no byte that cycle, go to HUNT and pulse error_out/error_count as a reject. A byte arriving in the expiry cycle wins: the timer clears and the byte is processed. Timer is held at 0 in HUNT.
- Back-to-back packets: a 0xA5 arriving on the cycle right after CHK is captured (HUNT is entered in the CHK-processing cycle).
- byte_valid_in is assumed at most 1 cycle wide, but multi-cycle pulses are treated as one byte per cycle. No backpressure.
- centroids_valid_out and error_out are never high in the same cycle.

Decomposition:
- Package centroid_pkt_pkg: SYNC_BYTE=8'hA5, PKT_PAYLOAD_BYTES=6, rx_state_t enum {HUNT, PAYLOAD, CHECK}, centroid_t struct {x[8:0], y[7:0]}, and a pack/unpack function pair shared with the transmitter side.
- One sub-module: byte_gap_timer (clear, enable, expire pulse; parameter TIMEOUT_CYCLES). The FSM and registers stay in centroid_packet_rx.

Test Plan:
- Valid packet A5 00 32 1E 01 0E 96 B5 (byte gaps 100 clks) -> one cycle after B5: c1=(50,30), c2=(270,150), valid pulse, frame_count=1, error_count=0.
- Same packet with CHK=B4 -> error_out pulse, outputs stay 0, error_count=1; then the correct packet -> accepted, frame_count=1.
- Garbage 00 FF A5 (restart) with payload byte 0x96 replaced by 0xA5 and CHK recomputed (0x96 XOR 0xA5 XOR B5 = 0x86) -> parsed as data, c2_y=165, accepted.
- Stop after 4 bytes, idle TIMEOUT_CYCLES -> error_out once, busy_out falls, error_count=1; a following full packet is accepted. Byte arriving exactly on the expiry cycle -> no timeout.
- Range/format: C1 x bytes 01 40 (x=320), or byte0=0x02, with valid CHK -> rejected; 300 rejected packets -> error_count_out=255 (saturates).
- Reset asserted (rst_in=0) after byte 5 -> state HUNT, outputs 0, no error pulse; two back-to-back valid packets with 0 gap -> two valid pulses, frame_count=2.
